// File: rtl/serial_pattern_tx_if.sv
// Word handshake between a producer and serial_pattern_tx.
// master drives the word, slave (the transmitter) answers with in_ready.
interface serial_pattern_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: shifts a DATA_W-bit word out MSB-first, then idles GAP cycles.
// Define SYNC_HDR_EN to prefix every frame with the 4-bit header 0,1,0,1.
module serial_pattern_tx #(
  parameter int   DATA_W     = 8,
  parameter int   GAP        = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  serial_pattern_tx_if.slave  bus,
  output logic                x,
  output logic                x_valid,
  output logic                done
);

  localparam int CW = $clog2(DATA_W);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] BIT_ZERO = CW'(0);
  localparam logic [CW-1:0] BIT_ONE  = CW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [GW-1:0] GAP_ZERO = GW'(0);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

`ifdef SYNC_HDR_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_DATA = 2'd2, ST_GAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd2, ST_GAP = 2'd3} state_t;
`endif

  state_t            state_r, state_n;
  logic [DATA_W-1:0] shift_r, shift_n;
  logic [CW-1:0]     bit_cnt_r, bit_cnt_n;
  logic [GW-1:0]     gap_cnt_r, gap_cnt_n;
  logic              x_r, x_n;
  logic              x_valid_r, x_valid_n;
  logic              done_r, done_n;
`ifdef SYNC_HDR_EN
  logic [1:0]        hdr_cnt_r, hdr_cnt_n;
`endif

  assign bus.in_ready = (state_r == ST_IDLE);
  assign x            = x_r;
  assign x_valid      = x_valid_r;
  assign done         = done_r;

  // Next-state and next-output decode; outputs fall back to an idle line each cycle.
  always_comb begin
    state_n   = state_r;
    shift_n   = shift_r;
    bit_cnt_n = bit_cnt_r;
    gap_cnt_n = gap_cnt_r;
    x_n       = IDLE_LEVEL;
    x_valid_n = 1'b0;
    done_n    = 1'b0;
`ifdef SYNC_HDR_EN
    hdr_cnt_n = hdr_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x_valid_n = 1'b1;
`ifdef SYNC_HDR_EN
          x_n       = 1'b0;
          shift_n   = bus.in_data;
          hdr_cnt_n = 2'd0;
          state_n   = ST_HDR;
`else
          x_n       = bus.in_data[DATA_W-1];
          shift_n   = bus.in_data << 1;
          bit_cnt_n = BIT_LAST;
          state_n   = ST_DATA;
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end
`ifdef SYNC_HDR_EN
      ST_HDR: begin
        x_valid_n = 1'b1;
        // Header bit k equals k[0], so the bit after index k is ~k[0].
        if (hdr_cnt_r != 2'd3) begin
          x_n       = ~hdr_cnt_r[0];
          hdr_cnt_n = hdr_cnt_r + 2'd1;
        end else begin
          x_n       = shift_r[DATA_W-1];
          shift_n   = shift_r << 1;
          bit_cnt_n = BIT_LAST;
          state_n   = ST_DATA;
        end
      end
`endif
      ST_DATA: begin
        if (bit_cnt_r != BIT_ZERO) begin
          x_n       = shift_r[DATA_W-1];
          x_valid_n = 1'b1;
          shift_n   = shift_r << 1;
          bit_cnt_n = bit_cnt_r - BIT_ONE;
        end else begin
          done_n    = 1'b1;
          gap_cnt_n = GAP_ZERO;
          state_n   = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          gap_cnt_n = GAP_ZERO;
          state_n   = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt_r + GAP_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset discards any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      shift_r   <= {DATA_W{1'b0}};
      bit_cnt_r <= BIT_ZERO;
      gap_cnt_r <= GAP_ZERO;
      x_r       <= IDLE_LEVEL;
      x_valid_r <= 1'b0;
      done_r    <= 1'b0;
`ifdef SYNC_HDR_EN
      hdr_cnt_r <= 2'd0;
`endif
    end else begin
      state_r   <= state_n;
      shift_r   <= shift_n;
      bit_cnt_r <= bit_cnt_n;
      gap_cnt_r <= gap_cnt_n;
      x_r       <= x_n;
      x_valid_r <= x_valid_n;
      done_r    <= done_n;
`ifdef SYNC_HDR_EN
      hdr_cnt_r <= hdr_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx (DATA_W=8, GAP=1); header frame checked when SYNC_HDR_EN is set.
module tb_serial_pattern_tx;
  localparam int DATA_W = 8;
  localparam int GAP    = 1;

  logic clk = 1'b0;
  logic reset;
  logic x, x_valid, done;
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_pattern_tx_if #(.DATA_W(DATA_W)) bus ();

  serial_pattern_tx #(.DATA_W(DATA_W), .GAP(GAP), .IDLE_LEVEL(1'b1)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .x       (x),
    .x_valid (x_valid),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0] got;
    reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {x, x_valid, done, bus.in_ready};
    n_cmp++;
    if (got !== 4'b1001) begin
      n_bad++;
      $display("FAIL reset_state: got {x,x_valid,done,in_ready}=%b want 1001", got);
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    got = {x, x_valid, done, bus.in_ready};
    n_cmp++;
    if (got !== 4'b1001) begin
      n_bad++;
      $display("FAIL reset_release: got {x,x_valid,done,in_ready}=%b want 1001", got);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] w;
    logic [3:0] got, exp;
    w = 8'hA5;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      got = {x, x_valid, done, bus.in_ready};
      exp = {(c <= 8) ? w[8-c] : 1'b1, (c <= 8), (c == 9), (c == 10)};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL single_a5 cycle %0d: got {x,x_valid,done,in_ready}=%b want %b", c, got, exp);
      end
      if (c == 1) bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1;
    logic [3:0] got, exp;
    logic       ex;
    w0 = 8'h0F;
    w1 = 8'hF0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c <= 8)       ex = w0[8-c];
      else if (c <= 10) ex = 1'b1;
      else if (c <= 18) ex = w1[18-c];
      else              ex = 1'b1;
      exp = {ex, ((c <= 8) || (c >= 11 && c <= 18)), (c == 9 || c == 19), (c == 10 || c == 20)};
      got = {x, x_valid, done, bus.in_ready};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: got {x,x_valid,done,in_ready}=%b want %b", c, got, exp);
      end
      if (c == 1)  bus.in_data  = w1;
      if (c == 11) bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w;
    logic [3:0] got, exp;
    w = 8'h3C;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      got = {x, x_valid, done, bus.in_ready};
      exp = {w[8-c], 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL mid_3c cycle %0d: got {x,x_valid,done,in_ready}=%b want %b", c, got, exp);
      end
    end
    reset = 1'b0;
    #1;
    got = {x, x_valid, done, bus.in_ready};
    n_cmp++;
    if (got !== 4'b1001) begin
      n_bad++;
      $display("FAIL mid_reset_immediate: got {x,x_valid,done,in_ready}=%b want 1001", got);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      got = {x, x_valid, done, bus.in_ready};
      n_cmp++;
      if (got !== 4'b1001) begin
        n_bad++;
        $display("FAIL mid_no_done cycle %0d: got {x,x_valid,done,in_ready}=%b want 1001", c, got);
      end
    end
    w = 8'h81;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      got = {x, x_valid, done, bus.in_ready};
      exp = {(c <= 8) ? w[8-c] : 1'b1, (c <= 8), (c == 9), (c == 10)};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL after_reset_81 cycle %0d: got {x,x_valid,done,in_ready}=%b want %b", c, got, exp);
      end
      if (c == 1) bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_data_stability();
    logic [7:0] w;
    logic [3:0] got, exp;
    w = 8'h55;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      got = {x, x_valid, done, bus.in_ready};
      exp = {(c <= 8) ? w[8-c] : 1'b1, (c <= 8), (c == 9), (c == 10)};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL stable_55 cycle %0d: got {x,x_valid,done,in_ready}=%b want %b", c, got, exp);
      end
      bus.in_valid = 1'b0;
      bus.in_data  = ~bus.in_data;
    end
  endtask

`ifdef SYNC_HDR_EN
  task automatic test_header();
    logic [7:0] w;
    logic [3:0] got, exp;
    logic       ex;
    w = 8'hFF;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c <= 4)       ex = ((c - 1) % 2 == 1);
      else if (c <= 12) ex = w[12-c];
      else              ex = 1'b1;
      exp = {ex, (c <= 12), (c == 13), 1'b0};
      got = {x, x_valid, done, bus.in_ready};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL header_ff cycle %0d: got {x,x_valid,done,in_ready}=%b want %b", c, got, exp);
      end
      bus.in_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
`ifdef SYNC_HDR_EN
    test_header();
`else
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_data_stability();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial frame transmitter: accepts a DATA_W-bit word over a valid/ready handshake and shifts it out MSB-first on a 1-bit line, one bit per clk.
- Transmit-side counterpart of the team's serial sequence detectors; drives their x input.
- Line idles at IDLE_LEVEL, with a programmable inter-frame gap, so detector state machines resynchronise between frames.

Parameters:
- DATA_W, 8, payload bits per frame; legal range >= 2.
- GAP, 1, idle cycles forced after each frame; legal range >= 0.
- IDLE_LEVEL, 1'b1, line value when no bit is being sent.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  asynchronous, active-low.
- in_valid  input  1  word offered.
- in_data  input  DATA_W  word to send.
- in_ready  output  1  block can accept a word.
- x  output  1  serial line, registered.
- x_valid  output  1  x carries a frame bit, registered.
- done  output  1  one-cycle pulse after the last bit, registered.

Behaviour:
- Reset values (reset low, applied immediately):
  - x = IDLE_LEVEL, x_valid = 0, done = 0.
  - State = IDLE, bit counter = 0, gap counter = 0.
  - in_ready = 1 (decoded from state).
- States:
  - IDLE: in_ready = 1.
  - DATA: in_ready = 0.
  - GAP: in_ready = 0.
  - in_ready is a combinational decode of state only; no dependence on in_valid.
- Handshake:
  - A transfer occurs on a posedge with in_valid & in_ready.
  - in_data is captured into the shift register on that edge.
  - Later changes to in_data are ignored.
  - in_valid without in_ready has no effect and need not be held by the block.
- IDLE to DATA, on the transfer edge:
  - x <= in_data[DATA_W-1], x_valid <= 1.
  - Shift register <= in_data shifted left by 1.
  - Bit counter <= DATA_W-1.
- Latency: MSB appears on x in the cycle immediately after the transfer edge.
- DATA, each edge:
  - If bit counter != 0: x <= shift register MSB, shift register shifts left, counter decrements.
  - If bit counter == 0 (last bit has been on x for one cycle): x <= IDLE_LEVEL, x_valid <= 0, done <= 1.
  - Next state from the last-bit edge: GAP when GAP > 0, else IDLE.
- GAP:
  - Holds x = IDLE_LEVEL, x_valid = 0.
  - Gap counter counts 0..GAP-1; returns to IDLE on the edge where counter == GAP-1.
- done:
  - High exactly one cycle: the first cycle after the last bit.
  - Cleared on the next edge.
- Frame period: minimum DATA_W + GAP + 1 cycles, because IDLE lasts at least one cycle per frame.
- x_valid is high for exactly DATA_W consecutive cycles per frame; never high in IDLE or GAP.
- Reset mid-frame:
  - Frame is discarded; all outputs return to reset values at once.
  - No done pulse.
  - First transfer after reset release behaves normally.
- in_valid during DATA/GAP: ignored. A word held valid is accepted on the first IDLE edge.

Optional Feature:
- Macro SYNC_HDR_EN.
- When defined:
  - Adds a HDR state between IDLE and DATA, emitting the fixed 4-bit header 0,1,0,1 with x_valid = 1.
  - Transfer edge loads x <= 0 and a 2-bit header counter.
  - After 4 header cycles, payload MSB follows with no gap.
  - x_valid is high for DATA_W+4 consecutive cycles.
  - Latency from transfer edge to payload MSB: 5 cycles. done follows the last payload bit as above.
  - Minimum frame period: DATA_W + GAP + 5.
- When not defined: no HDR state and no header logic; behaviour exactly as in Behaviour.

Test Plan:
- Reset check: assert reset with in_valid = 1 -> x = 1, x_valid = 0, done = 0, in_ready = 1; no transfer while reset is low.
- Single frame, DATA_W = 8, GAP = 1, 0xA5 accepted at edge 0:
  - x = 1,0,1,0,0,1,0,1 in cycles 1-8, x_valid = 1 in cycles 1-8.
  - done = 1 in cycle 9 only; in_ready = 0 in cycles 1-9, 1 in cycle 10.
- Back-to-back, in_valid held high with 0x0F then 0xF0:
  - Second word accepted at edge 10; x = 1,1,1,1,0,0,0,0 in cycles 11-18.
  - x = 1 with x_valid = 0 in cycles 9-10.
- Reset mid-frame, 0x3C, reset low during cycle 4 -> x = 1, x_valid = 0 immediately; no done; a subsequent 0x81 frame is exact.
- Data stability, in_data toggled every cycle after transfer of 0x55 -> x = 0,1,0,1,0,1,0,1 unaffected.
- SYNC_HDR_EN defined, send 0xFF -> x = 0,1,0,1,1,1,1,1,1,1,1,1 in cycles 1-12; x_valid high cycles 1-12; done in cycle 13.
